// File: rtl/morse_tx_sequencer.sv
// Morse sequencer: takes one ASCII char per handshake, fetches its on/off pattern from the LUT, and keys it LSB-first.
// Latency: transfer at edge k -> sel at k, first mark unit after k+1, char_ready again after k+1+(nbits+gap)*UNIT_CYCLES.
// Backpressure: char_ready only in IDLE; char_valid while busy is ignored (no buffering). Option MORSE_TONE_EN adds tone_out.
module morse_tx_sequencer #(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter int CHAR_GAP    = 3,
    parameter int WORD_GAP    = 4,
    parameter int TONE_HALF   = 25_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [6:0]  char_data,
    output logic        char_ready,
    output logic [6:0]  sel,
    input  logic [21:0] pattern,
    output logic        morse_out,
    output logic        busy
`ifdef MORSE_TONE_EN
    , output logic      tone_out
`endif
);

    localparam int UW = $clog2(UNIT_CYCLES);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

    // Reject parameter values the counters cannot represent.
    if (UNIT_CYCLES < 2 || TONE_HALF < 1 || CHAR_GAP < 1 || CHAR_GAP > 7 ||
        WORD_GAP < 1 || WORD_GAP > 7) begin : g_bad_param
        $error("morse_tx_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t          state;
    logic [UW-1:0]   unit_cnt;
    logic [2:0]      gap_cnt;
    logic [21:0]     shreg;
    logic            unit_end;

    assign unit_end   = (unit_cnt == UNIT_LAST);
    assign char_ready = (state == IDLE);
    assign busy       = ~char_ready;

    // Main sequencer: accept, capture LUT pattern, shift one bit per unit, then pad with gap units.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            morse_out <= 1'b0;
            unit_cnt  <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        sel   <= char_data;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg    <= pattern;
                    unit_cnt <= '0;
                    if (pattern != '0) begin
                        state     <= SEND;
                        morse_out <= pattern[0];
                    end else begin
                        // Space and unmapped codes: a bare word gap.
                        state     <= GAP;
                        gap_cnt   <= 3'(WORD_GAP);
                        morse_out <= 1'b0;
                    end
                end
                SEND: begin
                    if (unit_end) begin
                        unit_cnt <= '0;
                        shreg    <= shreg >> 1;
                        // Highest set bit is the last element of the char.
                        if (shreg[21:1] == '0) begin
                            state     <= GAP;
                            gap_cnt   <= 3'(CHAR_GAP);
                            morse_out <= 1'b0;
                        end else begin
                            morse_out <= shreg[1];
                        end
                    end else begin
                        unit_cnt <= unit_cnt + UW'(1);
                    end
                end
                GAP: begin
                    morse_out <= 1'b0;
                    if (unit_end) begin
                        unit_cnt <= '0;
                        gap_cnt  <= gap_cnt - 3'd1;
                        if (gap_cnt == 3'd1) begin
                            state <= IDLE;
                        end
                    end else begin
                        unit_cnt <= unit_cnt + UW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MORSE_TONE_EN
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    logic [TW-1:0] tone_cnt;

    // Square wave keyed by morse_out; held at zero between marks so each mark starts in the low phase.
    always_ff @(posedge clk) begin
        if (reset || !morse_out) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_out <= ~tone_out;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Bench for morse_tx_sequencer: directed cases plus random chars against a waveform model built from the LUT table.
// Latency: model expects first unit one cycle after the LOAD cycle and char_ready after (nbits+gap)*U more cycles.
// Backpressure: exercises char_valid noise and held-valid back-to-back transfers while busy.
module tb_morse_tx_sequencer;

    localparam int U  = 4;
    localparam int CG = 3;
    localparam int WG = 4;
    localparam int TH = 2;

    localparam logic [6:0] C_E   = 7'h45;
    localparam logic [6:0] C_T   = 7'h54;
    localparam logic [6:0] C_A   = 7'h41;
    localparam logic [6:0] C_SP  = 7'h20;
    localparam logic [6:0] C_DEL = 7'h7F;
    localparam logic [6:0] C_8   = 7'h38;
    localparam logic [6:0] C_9   = 7'h39;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [6:0]  char_data = '0;
    logic        char_ready;
    logic [6:0]  sel;
    logic [21:0] pattern;
    logic        morse_out;
    logic        busy;
`ifdef MORSE_TONE_EN
    logic        tone_out;
`endif

    logic [21:0] lut [128];
    logic [6:0]  letters [8];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always_comb pattern = lut[sel];

    morse_tx_sequencer #(
        .UNIT_CYCLES(U), .CHAR_GAP(CG), .WORD_GAP(WG), .TONE_HALF(TH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .char_valid(char_valid),
        .char_data(char_data),
        .char_ready(char_ready),
        .sel(sel),
        .pattern(pattern),
        .morse_out(morse_out),
        .busy(busy)
`ifdef MORSE_TONE_EN
        , .tone_out(tone_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbits(input logic [21:0] p);
        int n = 0;
        for (int i = 0; i < 22; i++) if (p[i]) n = i + 1;
        return n;
    endfunction

    // Present c and wait (bounded) for the handshake; returns with the transfer edge just passed.
    task automatic start_char(input logic [6:0] c, output int waits);
        char_valid = 1'b1;
        char_data  = c;
        waits = 0;
        while (!char_ready && waits < 300) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!char_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        char_valid = 1'b0;
        char_data  = 7'($urandom);
        check("sel", 32'(sel), 32'(c));
        check("busy_load", 32'(busy), 32'd1);
        check("morse_load", 32'(morse_out), 32'd0);
    endtask

    // Check the whole keyed waveform of c. mode 0: valid low, 1: random noise, 2: hold valid with hold_c.
    task automatic expect_char(input logic [6:0] c, input int mode, input logic [6:0] hold_c);
        logic [21:0] p;
        int n, g, len, run;
        logic e;
        p   = lut[c];
        n   = nbits(p);
        g   = (n == 0) ? WG : CG;
        len = (n + g) * U;
        run = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            e = (i < n * U) ? p[i / U] : 1'b0;
            check("morse", 32'(morse_out), 32'(e));
`ifdef MORSE_TONE_EN
            check("tone", 32'(tone_out), 32'((run / TH) % 2));
`endif
            run = e ? run + 1 : 0;
            if (i == len / 2) check("ready_mid", 32'(char_ready), 32'd0);
            if (mode == 1 && i < len - 1) begin
                char_valid = 1'($urandom);
                char_data  = 7'($urandom);
            end else if (mode == 2) begin
                char_valid = 1'b1;
                char_data  = hold_c;
            end else begin
                char_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("ready_end", 32'(char_ready), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("morse_end", 32'(morse_out), 32'd0);
        check("sel_hold", 32'(sel), 32'(c));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        logic [6:0] c;

        for (int i = 0; i < 128; i++) lut[i] = '0;
        lut[C_E]   = 22'h1;      // .
        lut[C_T]   = 22'h7;      // -
        lut[C_A]   = 22'h1D;     // .-
        lut[7'h49] = 22'h5;      // I ..
        lut[7'h4E] = 22'h17;     // N -.
        lut[7'h53] = 22'h15;     // S ...
        lut[7'h4D] = 22'h77;     // M --
        lut[7'h4F] = 22'h777;    // O ---
        for (int d = 0; d < 8; d++) lut[7'h30 + d] = 22'($urandom_range(1, 22'h3FFFFF));
        lut[C_8] = 22'h200000;
        lut[C_9] = 22'h3FFFFF;
        letters = '{C_E, C_T, C_A, 7'h49, 7'h4E, 7'h53, 7'h4D, 7'h4F};

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_morse", 32'(morse_out), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
`ifdef MORSE_TONE_EN
        check("rst_tone", 32'(tone_out), 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        // Single dot, dot-dash, space and unmapped code.
        start_char(C_E, w);   expect_char(C_E, 0, 7'h0);
        start_char(C_A, w);   expect_char(C_A, 1, 7'h0);
        start_char(C_SP, w);  expect_char(C_SP, 0, 7'h0);
        start_char(C_DEL, w); expect_char(C_DEL, 1, 7'h0);

        // Widest patterns: only the top bit set, and all 22 bits set.
        start_char(C_8, w);   expect_char(C_8, 0, 7'h0);
        start_char(C_9, w);   expect_char(C_9, 0, 7'h0);

        // Valid held through 'E' with 'T' waiting: 'T' taken as soon as ready returns.
        start_char(C_E, w);   expect_char(C_E, 2, C_T);
        start_char(C_T, w);
        check("b2b_wait", 32'(w), 32'd0);
        expect_char(C_T, 0, 7'h0);

        // Reset in the middle of a dash.
        start_char(C_T, w);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("dash", 32'(morse_out), 32'd1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_morse", 32'(morse_out), 32'd0);
        check("mid_rst_ready", 32'(char_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
`ifdef MORSE_TONE_EN
        check("mid_rst_tone", 32'(tone_out), 32'd0);
`endif
        @(posedge clk); #1;
        check("post_rst_idle", 32'(char_ready), 32'd1);
        start_char(C_E, w);   expect_char(C_E, 0, 7'h0);

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: c = letters[$urandom_range(0, 7)];
                1: c = 7'(7'h30 + $urandom_range(0, 9));
                2: c = ($urandom_range(0, 1) == 0) ? C_SP : C_DEL;
                default: c = 7'($urandom_range(0, 127));
            endcase
            start_char(c, w);
            expect_char(c, $urandom_range(0, 1), 7'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
